button_toggle_en: RTL and testbench
===================================

Name: button_toggle_en

Overview:
Conditions a raw board push-button and turns it into the run/pause enable for the seconds counter stage directly downstream. The raw input passes through a 2-flop synchroniser, then a debounce FSM. Each confirmed press toggles a level enable (en_out, wired to the counter's en) and emits a one-cycle press strobe. Single clock domain (125 MHz board clock).

Parameters:
DEBOUNCE_CYCLES, 1250000, cycles btn must be stable to confirm press/release (10 ms @125 MHz); legal range >= 2
EN_RESET, 1'b1, value of en_out after reset (counter runs out of reset)
LONG_CYCLES, 250000000, hold time for long-press clear (2 s); used only with LONG_PRESS_EN

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_in  input  1  raw, asynchronous, bouncy button (1 = pressed)
en_out  output  1  toggling enable level, drives counter en
press_pulse  output  1  one-cycle strobe per confirmed press
clr_pulse  output  1  one-cycle long-press strobe, drives counter rst (tied 0 without LONG_PRESS_EN)

Behaviour:
- Reset (async assert, released on clk): sync flops=0, state=IDLE, cnt=0, en_out=EN_RESET, press_pulse=0, clr_pulse=0. All outputs registered.
- btn_s = 2nd synchroniser flop; only btn_s feeds the FSM.
- cnt width = $clog2(DEBOUNCE_CYCLES+1); cnt saturates at DEBOUNCE_CYCLES-1, never wraps.
- FSM states: IDLE, ARM, HELD, DISARM.
  - IDLE: btn_s=1 -> ARM, cnt<=0.
  - ARM: btn_s=0 -> IDLE (bounce rejected, no output change). btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, en_out<=~en_out, press_pulse<=1. Otherwise cnt++.
  - HELD: btn_s=0 -> DISARM, cnt<=0. Else stay.
  - DISARM: btn_s=1 -> HELD (release bounce, no new press). btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
- Latency: btn_in high and stable from sample edge 0 -> btn_s=1 after edge 1 -> ARM after edge 2 -> press_pulse/en_out update after edge DEBOUNCE_CYCLES+2.
- press_pulse is high exactly one cycle per press, however long the hold. No repeat while held.
- A bounce anywhere in ARM restarts qualification from IDLE. Glitch shorter than DEBOUNCE_CYCLES: no effect.
- A press is registered only after a full debounced release (DISARM -> IDLE).
- Reset mid-press: immediate return to reset values. A button still held at reset release must pass full qualification before it counts.

Optional Feature:
LONG_PRESS_EN:
- Defined: a hold counter (width $clog2(LONG_CYCLES+1)) clears on entry to HELD and counts while in HELD or DISARM. When it reaches LONG_CYCLES-1 with btn_s=1, clr_pulse=1 for one cycle, once per press; the counter then saturates. en_out is unaffected, because the toggle already occurred at the press.
- Undefined: no hold counter; clr_pulse constant 0.

Decomposition:
- Shared package btn_pkg: FSM state encodings (2-bit localparams ST_IDLE=0, ST_ARM=1, ST_HELD=2, ST_DISARM=3) and CLK_HZ=125000000 for deriving the time-based defaults.
- One sub-module: sync_2ff (1-bit, async reset to 0), reusable for other board inputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, EN_RESET=1):
- Reset check: assert rst mid-cycle -> en_out=1, press_pulse=0, clr_pulse=0 immediately, without waiting for a clk edge.
- Clean press: btn_in 0->1 held 20 cycles -> press_pulse high exactly 1 cycle, 6 edges after first high sample; en_out 1->0.
- Bounce: btn_in pulses 1 for 2 cycles, 0 for 1, repeated 3 times, then stays 0 -> no press_pulse, en_out unchanged, FSM back to IDLE.
- Release bounce: after a confirmed press, btn_in toggles 1/0 each cycle for 3 cycles, then held 0 for 10 -> no second press_pulse; next clean press toggles en_out back to 1.
- Reset mid-ARM: rst asserted 2 cycles after btn_s=1 with btn_in held -> outputs at reset values; after release, press_pulse appears 6 edges later (DEBOUNCE_CYCLES+2).
- LONG_PRESS_EN: hold btn_in 30 cycles -> one press_pulse, then one clr_pulse 10 cycles after the HELD entry; without the macro, clr_pulse stays 0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioning block: debounce FSM
// encodings and the board clock used to derive time-based defaults.
package btn_pkg;

    localparam int unsigned CLK_HZ = 125_000_000;

    localparam int unsigned DEBOUNCE_DEFAULT = CLK_HZ / 100;  // 10 ms
    localparam int unsigned LONG_DEFAULT     = 2 * CLK_HZ;    // 2 s

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_HELD   = 2'd2,
        ST_DISARM = 2'd3
    } state_t;

endpackage

// File: rtl/button_toggle_en_if.sv
// Button-side signal bundle: raw button in, enable level and strobes out.
interface button_toggle_en_if;

    logic btn_in;
    logic en_out;
    logic press_pulse;
    logic clr_pulse;

    modport master (output btn_in, input en_out, input press_pulse, input clr_pulse);
    modport slave  (input btn_in, output en_out, output press_pulse, output clr_pulse);

endinterface

// File: rtl/button_toggle_en_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_toggle_en.sv
// Debounced push-button to run/pause toggle with press strobe.
// Optional long-press clear strobe enabled by defining LONG_PRESS_EN.
module button_toggle_en
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic        EN_RESET        = 1'b1,
    parameter int unsigned LONG_CYCLES     = LONG_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    button_toggle_en_if.slave  bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("button_toggle_en: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    logic          btn_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          press_q, press_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (btn_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            en_q    <= EN_RESET;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            press_q <= press_d;
        end
    end

    // cnt only advances below CNT_LAST, so it saturates instead of wrapping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        press_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    en_d    = ~en_q;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_DISARM;
                    cnt_d   = '0;
                end
            end
            ST_DISARM: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.en_out      = en_q;
    assign bus.press_pulse = press_q;

`ifdef LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic          clr_q, clr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            clr_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            clr_q  <= clr_d;
        end
    end

    // Parking at HOLD_DONE after firing keeps the strobe to once per press;
    // a release bounce back into HELD does not restart the hold time.
    always_comb begin
        hold_d = hold_q;
        clr_d  = 1'b0;
        if (state_q == ST_ARM && state_d == ST_HELD) begin
            hold_d = '0;
        end else if (state_q == ST_HELD || state_q == ST_DISARM) begin
            if (hold_q == HOLD_LAST) begin
                if (btn_s) begin
                    clr_d  = 1'b1;
                    hold_d = HOLD_DONE;
                end
            end else if (hold_q != HOLD_DONE) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    assign bus.clr_pulse = clr_q;
`else
    assign bus.clr_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_toggle_en.sv
// Bench for button_toggle_en: table of button waveforms with a scoreboard
// of expected strobe cycles, plus hand-written reset sequences.
module tb_button_toggle_en;

    localparam int D = 4;
    localparam int L = 10;

`ifdef LONG_PRESS_EN
    localparam bit LONG = 1'b1;
`else
    localparam bit LONG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    button_toggle_en_if bus ();

    button_toggle_en #(
        .DEBOUNCE_CYCLES (D),
        .EN_RESET        (1'b1),
        .LONG_CYCLES     (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #4 clk = ~clk;

    typedef struct {
        string      name;
        int         ones;   // leading cycles of btn_in=1
        logic [7:0] tail;   // following bits, MSB first
        int         tlen;
        int         press;  // cycle index of expected press strobe, -1 none
        int         clr;    // cycle index of expected long-press strobe, -1 none
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    logic exp_en;
    int   press_q[$];
    int   clr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        int total;
        int e;
        total = v.ones + v.tlen + 14;
        press_q.delete();
        clr_q.delete();
        if (v.press >= 0) press_q.push_back(v.press);
        if (LONG && v.clr >= 0) clr_q.push_back(v.clr);
        for (int i = 0; i < total; i++) begin
            if (i < v.ones)               bus.btn_in = 1'b1;
            else if (i - v.ones < v.tlen) bus.btn_in = v.tail[v.tlen - 1 - (i - v.ones)];
            else                          bus.btn_in = 1'b0;
            @(posedge clk);
            #1;
            if (bus.press_pulse === 1'b1) begin
                if (press_q.size() == 0) begin
                    check({v.name, " unexpected press at cycle"}, i, 32'hFFFF_FFFF);
                end else begin
                    e = press_q.pop_front();
                    check({v.name, " press cycle"}, i, e);
                    exp_en = ~exp_en;
                    check({v.name, " en at press"}, bus.en_out, exp_en);
                end
            end
            if (bus.clr_pulse === 1'b1) begin
                if (clr_q.size() == 0) begin
                    check({v.name, " unexpected clr at cycle"}, i, 32'hFFFF_FFFF);
                end else begin
                    e = clr_q.pop_front();
                    check({v.name, " clr cycle"}, i, e);
                end
            end
        end
        check({v.name, " missing press"}, press_q.size(), 0);
        check({v.name, " missing clr"}, clr_q.size(), 0);
        check({v.name, " en final"}, bus.en_out, exp_en);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        vecs[0] = '{"clean20",     20, 8'h00,       0,  6, 16};
        vecs[1] = '{"bounce",       2, 8'b0110110,  7, -1, -1};
        vecs[2] = '{"glitch4",      4, 8'h00,       0, -1, -1};
        vecs[3] = '{"min5",         5, 8'h00,       0,  6, -1};
        vecs[4] = '{"rel_bounce",  10, 8'b010,      3,  6, -1};
        vecs[5] = '{"clean8",       8, 8'h00,       0,  6, -1};
        vecs[6] = '{"long30",      30, 8'h00,       0,  6, 16};

        bus.btn_in = 1'b0;
        rst        = 1'b1;
        exp_en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset en", bus.en_out, 1'b1);
        check("reset press", bus.press_pulse, 1'b0);
        check("reset clr", bus.clr_pulse, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) apply(vecs[k]);

        // Reset mid-ARM: btn_s high after edge 1, ARM after edge 2
        check("pre-reset en", bus.en_out, exp_en);
        bus.btn_in = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async reset en", bus.en_out, 1'b1);
        check("async reset press", bus.press_pulse, 1'b0);
        check("async reset clr", bus.clr_pulse, 1'b0);
        exp_en = 1'b1;
        @(posedge clk);
        #1;
        check("held reset en", bus.en_out, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        v = '{"rst_midarm", 20, 8'h00, 0, 6, 16};
        apply(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
